// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: widths, state encodings and the
// clocks-per-bit calculation. The state encodings match the uart_tx block.
package uart_rx_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned BIT_W   = 3;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4,
    S_BREAK = 3'd5
  } rx_state_e;

  // Clocks per bit for a clock in MHz and a baud rate in bit/s.
  function automatic int unsigned calc_cycle(input int unsigned clk_fre,
                                             input int unsigned baud_rate);
    longint unsigned num;
    num = 64'(clk_fre) * 64'd1000000;
    return 32'(num / 64'(baud_rate));
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake plus status flags.
//  master: the receiver (drives data/valid/flags/busy, reads ready)
//  slave : the consumer (reads everything, drives ready)
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_data_valid;
  logic              rx_data_ready;
  logic              rx_frame_err;
  logic              rx_overrun;
  logic              rx_busy;

  modport master (
    output rx_data, rx_data_valid, rx_frame_err, rx_overrun, rx_busy,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data, rx_data_valid, rx_frame_err, rx_overrun, rx_busy,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Ports: clk, rst_n (async, active-low), d (async input), q (synchronised).
// Flops reset to 1 so an idle-high line shows no false edge out of reset.
module uart_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '1;
    else        chain_q <= {chain_q[STAGES-2:0], d};
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Ports:
//  clk, rst_n  clock and async active-low reset
//  rx_pin      asynchronous serial input, idles high
//  rx_if       master side of uart_rx_if: rx_data/rx_data_valid held until
//              rx_data_ready; rx_frame_err and rx_overrun are 1-cycle pulses;
//              rx_busy is high whenever the FSM is out of S_IDLE.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FRE   = 50,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx_pin,
  uart_rx_if.master rx_if
);

  localparam int unsigned CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam int unsigned HALF  = CYCLE / 2;
  localparam logic [CNT_W-1:0] CYCLE_LAST = CNT_W'(CYCLE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF - 1);

  if (CYCLE < 4 || CYCLE > 65535) begin : g_cycle_range
    $error("uart_rx: clocks per bit out of range 4..65535");
  end

  logic              rx_s;
  logic              rx_prev;
  rx_state_e         state_q, state_next;
  logic [CNT_W-1:0]  cnt_q, cnt_next;
  logic [BIT_W-1:0]  bit_q, bit_next;
  logic [DATA_W-1:0] shift_q, shift_next;
  logic              deliver_c;
  logic              frame_err_c;

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic              busy_q;

  // Line synchroniser and one-clock delay for falling-edge detection.
  uart_rx_sync #(.STAGES(2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_pin),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_prev <= 1'b1;
    else        rx_prev <= rx_s;
  end

  // FSM state register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_next;
      cnt_q   <= cnt_next;
      bit_q   <= bit_next;
      shift_q <= shift_next;
    end
  end

  // Next state, counters, shift register and deliver/error strobes.
  always_comb begin
    state_next  = state_q;
    cnt_next    = cnt_q + CNT_W'(1);
    bit_next    = bit_q;
    shift_next  = shift_q;
    deliver_c   = 1'b0;
    frame_err_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_next = '0;
        if (rx_prev && !rx_s) state_next = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) state_next = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt_q == CYCLE_LAST) begin
          shift_next[bit_q] = rx_s;
          bit_next          = bit_q + BIT_W'(1);
          cnt_next          = '0;
          if (bit_q == BIT_W'(7)) state_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (cnt_q == CYCLE_LAST) begin
          if (rx_s) begin
            deliver_c  = 1'b1;
            state_next = S_IDLE;
          end else begin
            frame_err_c = 1'b1;
            state_next  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A line held low must return high before a new start is accepted.
        cnt_next = '0;
        if (rx_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (state_next != state_q) cnt_next = '0;
  end

  // Output handshake, overrun and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= frame_err_c;
      overrun_q   <= 1'b0;
      busy_q      <= (state_next != S_IDLE);
      if (deliver_c) begin
        // A byte accepted on this edge frees the slot for the new one.
        if (!valid_q || rx_if.rx_data_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx_if.rx_data_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_data_valid = valid_q;
  assign rx_if.rx_frame_err  = frame_err_q;
  assign rx_if.rx_overrun    = overrun_q;
  assign rx_if.rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 MHz / 115200 baud (434 clocks per bit).
module tb_uart_rx;

  localparam int unsigned CYCLE   = 434;
  localparam int unsigned HALF    = CYCLE / 2;
  localparam int unsigned LAT_NOM = 2 + HALF + 9 * CYCLE;

  logic clk;
  logic rst_n;
  logic rx_pin;

  uart_rx_if rx_if ();

  uart_rx #(.CLK_FRE(50), .BAUD_RATE(115200)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_pin (rx_pin),
    .rx_if  (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer log and flag pulse counters, sampled mid-cycle.
  logic [7:0]  rx_q[$];
  int unsigned cyc_q[$];
  int unsigned ferr_cnt = 0;
  int unsigned ovr_cnt  = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_if.rx_data_valid && rx_if.rx_data_ready) begin
        rx_q.push_back(rx_if.rx_data);
        cyc_q.push_back(cyc);
      end
      if (rx_if.rx_frame_err) ferr_cnt = ferr_cnt + 1;
      if (rx_if.rx_overrun)   ovr_cnt  = ovr_cnt + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int unsigned fall_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_pin   = 1'b0;
    fall_cyc = cyc;
    tick(CYCLE);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      tick(CYCLE);
    end
    rx_pin = stop;
    tick(CYCLE);
  endtask

  task automatic clear_log();
    rx_q.delete();
    cyc_q.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
  endtask

  initial begin
    int unsigned lat;
    logic [7:0] partial;
    partial = 8'h99;
    rst_n   = 1'b0;
    rx_pin  = 1'b1;
    rx_if.rx_data_ready = 1'b1;
    tick(4);

    // Reset values
    check("rst_data",  32'(rx_if.rx_data),       32'h0);
    check("rst_valid", 32'(rx_if.rx_data_valid), 32'h0);
    check("rst_ferr",  32'(rx_if.rx_frame_err),  32'h0);
    check("rst_ovr",   32'(rx_if.rx_overrun),    32'h0);
    check("rst_busy",  32'(rx_if.rx_busy),       32'h0);
    rst_n = 1'b1;
    tick(20);

    // 1: single byte 0xA5
    clear_log();
    send_byte(8'hA5, 1'b1);
    tick(CYCLE);
    check("t1_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) begin
      check("t1_data", 32'(rx_q[0]), 32'hA5);
      lat = cyc_q[0] - fall_cyc;
      check("t1_latency", 32'(lat + 1 >= LAT_NOM && lat <= LAT_NOM + 1), 32'd1);
    end
    check("t1_ferr", 32'(ferr_cnt), 32'd0);
    check("t1_ovr",  32'(ovr_cnt),  32'd0);
    check("t1_busy", 32'(rx_if.rx_busy), 32'h0);

    // 2: back-to-back 0x00, 0xFF, 0x55
    clear_log();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h55, 1'b1);
    tick(CYCLE);
    check("t2_count", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      check("t2_byte0", 32'(rx_q[0]), 32'h00);
      check("t2_byte1", 32'(rx_q[1]), 32'hFF);
      check("t2_byte2", 32'(rx_q[2]), 32'h55);
    end
    check("t2_flags", 32'(ferr_cnt + ovr_cnt), 32'd0);

    // 3: 100-clock glitch shorter than half a bit
    clear_log();
    rx_pin = 1'b0;
    tick(50);
    check("t3_busy_low", 32'(rx_if.rx_busy), 32'h1);
    tick(50);
    rx_pin = 1'b1;
    tick(2 * CYCLE);
    check("t3_count", 32'(rx_q.size()), 32'd0);
    check("t3_flags", 32'(ferr_cnt + ovr_cnt), 32'd0);
    check("t3_busy",  32'(rx_if.rx_busy), 32'h0);

    // 4: framing error, break, then recovery with 0x81
    clear_log();
    send_byte(8'h3C, 1'b0);
    tick(2000);
    check("t4_busy_break", 32'(rx_if.rx_busy), 32'h1);
    check("t4_ferr", 32'(ferr_cnt), 32'd1);
    rx_pin = 1'b1;
    tick(CYCLE);
    check("t4_idle_after_break", 32'(rx_if.rx_busy), 32'h0);
    send_byte(8'h81, 1'b1);
    tick(CYCLE);
    check("t4_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("t4_data", 32'(rx_q[0]), 32'h81);
    check("t4_ferr_total", 32'(ferr_cnt), 32'd1);
    check("t4_ovr", 32'(ovr_cnt), 32'd0);

    // 5: overrun with consumer stalled
    clear_log();
    rx_if.rx_data_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(CYCLE);
    check("t5_valid", 32'(rx_if.rx_data_valid), 32'h1);
    check("t5_data",  32'(rx_if.rx_data),       32'h11);
    check("t5_ovr",   32'(ovr_cnt),             32'd1);
    check("t5_ferr",  32'(ferr_cnt),            32'd0);
    rx_if.rx_data_ready = 1'b1;
    tick(1);
    check("t5_valid_drop", 32'(rx_if.rx_data_valid), 32'h0);
    check("t5_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("t5_accepted", 32'(rx_q[0]), 32'h11);

    // 6: reset mid-data of 0x99, then 0x42
    clear_log();
    rx_pin = 1'b0;
    tick(CYCLE);
    for (int i = 0; i < 3; i++) begin
      rx_pin = partial[i];
      tick(CYCLE);
    end
    check("t6_busy_pre", 32'(rx_if.rx_busy), 32'h1);
    rst_n = 1'b0;
    tick(2);
    check("t6_rst_data",  32'(rx_if.rx_data),       32'h0);
    check("t6_rst_valid", 32'(rx_if.rx_data_valid), 32'h0);
    check("t6_rst_busy",  32'(rx_if.rx_busy),       32'h0);
    check("t6_rst_flags", 32'(rx_if.rx_frame_err | rx_if.rx_overrun), 32'h0);
    rx_pin = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(CYCLE);
    send_byte(8'h42, 1'b1);
    tick(CYCLE);
    check("t6_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("t6_data", 32'(rx_q[0]), 32'h42);
    check("t6_flags", 32'(ferr_cnt + ovr_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
